// File: rtl/clk_gen_ctrl_if.sv
// Bundle of the config handshake and waveform outputs of clk_gen_ctrl.
// The master side is the config/enable source; the slave side is the generator.
interface clk_gen_ctrl_if #(
  parameter int W = 8
);
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_high;
  logic         cfg_err;
  logic         clk_out;
  logic         rise_tick;
  logic         fall_tick;
  logic         period_done;
  logic         running;
  logic [W-1:0] active_period;
  logic [W-1:0] active_high;

  modport master (
    output en, cfg_valid, cfg_period, cfg_high,
    input  cfg_ready, cfg_err, clk_out, rise_tick, fall_tick, period_done,
    input  running, active_period, active_high
  );

  modport slave (
    input  en, cfg_valid, cfg_period, cfg_high,
    output cfg_ready, cfg_err, clk_out, rise_tick, fall_tick, period_done,
    output running, active_period, active_high
  );
endinterface

// File: rtl/clk_gen_ctrl.sv
// Programmable divided-clock generator with glitch-free start/stop and
// period-aligned reconfiguration. All outputs are registered.
module clk_gen_ctrl #(
  parameter int W          = 8,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  clk_gen_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam logic [W-1:0] DEF_P = W'(DEF_PERIOD);
  localparam logic [W-1:0] DEF_H = W'(DEF_HIGH);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] act_p_q, act_p_d;
  logic [W-1:0] act_h_q, act_h_d;
  logic         pend_v_q, pend_v_d;
  logic [W-1:0] pend_p_q, pend_p_d;
  logic [W-1:0] pend_h_q, pend_h_d;
  logic         clk_out_q, clk_out_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;
  logic         done_q, done_d;
  logic         running_q, running_d;
  logic         ready_q, ready_d;
  logic         err_q, err_d;

  logic         wrap_s;
  logic         accept_s;
  logic         legal_s;

  // Next-state, config acceptance and the waveform of the upcoming cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_p_d  = act_p_q;
    act_h_d  = act_h_q;
    pend_v_d = pend_v_q;
    pend_p_d = pend_p_q;
    pend_h_d = pend_h_q;

    wrap_s   = (cnt_q == (act_p_q - W'(1)));
    accept_s = bus.cfg_valid && ready_q;
    legal_s  = (bus.cfg_period >= W'(2)) && (bus.cfg_high != '0) &&
               (bus.cfg_high < bus.cfg_period);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A config accepted on the final boundary edge is still held here.
        if (pend_v_q) begin
          act_p_d  = pend_p_q;
          act_h_d  = pend_h_q;
          pend_v_d = 1'b0;
        end else if (accept_s && legal_s) begin
          act_p_d = bus.cfg_period;
          act_h_d = bus.cfg_high;
        end else begin
          act_p_d = act_p_q;
        end
        if (bus.en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN, STOPPING: begin
        if (wrap_s) begin
          cnt_d = '0;
          if (pend_v_q) begin
            act_p_d  = pend_p_q;
            act_h_d  = pend_h_q;
            pend_v_d = 1'b0;
          end else begin
            pend_v_d = 1'b0;
          end
          state_d = bus.en ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + W'(1);
          state_d = bus.en ? RUN : STOPPING;
        end
        if (accept_s && legal_s) begin
          pend_v_d = 1'b1;
          pend_p_d = bus.cfg_period;
          pend_h_d = bus.cfg_high;
        end else begin
          pend_p_d = pend_p_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    err_d     = accept_s && !legal_s;
    ready_d   = !pend_v_d;
    running_d = (state_d != IDLE);
    clk_out_d = running_d && (cnt_d < act_h_d);
    rise_d    = running_d && (cnt_d == '0);
    fall_d    = running_d && (cnt_d == act_h_d);
    done_d    = running_d && (cnt_d == (act_p_d - W'(1)));
  end

  // State, counters, config registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_p_q   <= DEF_P;
      act_h_q   <= DEF_H;
      pend_v_q  <= 1'b0;
      pend_p_q  <= '0;
      pend_h_q  <= '0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_p_q   <= act_p_d;
      act_h_q   <= act_h_d;
      pend_v_q  <= pend_v_d;
      pend_p_q  <= pend_p_d;
      pend_h_q  <= pend_h_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      done_q    <= done_d;
      running_q <= running_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign bus.cfg_ready     = ready_q;
  assign bus.cfg_err       = err_q;
  assign bus.clk_out       = clk_out_q;
  assign bus.rise_tick     = rise_q;
  assign bus.fall_tick     = fall_q;
  assign bus.period_done   = done_q;
  assign bus.running       = running_q;
  assign bus.active_period = act_p_q;
  assign bus.active_high   = act_h_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Scoreboard bench for clk_gen_ctrl: stimulus queues hand-derived per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_clk_gen_ctrl;

  logic clk;
  logic rst;

  clk_gen_ctrl_if #(.W(8)) bus ();

  clk_gen_ctrl #(.W(8), .DEF_PERIOD(4), .DEF_HIGH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [6:0] flags;  // {clk_out, rise, fall, done, running, ready, err}
    logic [7:0] ap;
    logic [7:0] ah;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare one queued expectation per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {bus.clk_out, bus.rise_tick, bus.fall_tick, bus.period_done,
             bus.running, bus.cfg_ready, bus.cfg_err};
      checks++;
      if (act !== e.flags || bus.active_period !== e.ap || bus.active_high !== e.ah) begin
        failures++;
        $display("FAIL %s: got flags=%b p=%0d h=%0d, expected flags=%b p=%0d h=%0d",
                 e.tag, act, bus.active_period, bus.active_high, e.flags, e.ap, e.ah);
      end
    end
  end

  task automatic cyc(input string tag, input logic co, input logic ri, input logic fa,
                     input logic pd, input logic rn, input logic rdy, input logic er,
                     input logic [7:0] ap, input logic [7:0] ah);
    exp_t e;
    @(posedge clk);
    e.tag   = tag;
    e.flags = {co, ri, fa, pd, rn, rdy, er};
    e.ap    = ap;
    e.ah    = ah;
    exp_q.push_back(e);
    #1;
  endtask

  // One running period given as a clk_out pattern; en drops after cycle off_at.
  task automatic per(input string tag, input string pat, input logic [7:0] ap,
                     input logic [7:0] ah, input int off_at);
    for (int i = 0; i < pat.len(); i++) begin
      logic co;
      logic prev;
      co   = (pat[i] == 8'h31);
      prev = (i == 0) ? 1'b0 : (pat[i-1] == 8'h31);
      cyc(tag, co, (i == 0), (!co && prev), (i == pat.len() - 1), 1'b1, 1'b1, 1'b0, ap, ah);
      if (i == off_at) bus.en = 1'b0;
    end
  endtask

  task automatic set_cfg(input logic v, input logic [7:0] p, input logic [7:0] h);
    bus.cfg_valid  = v;
    bus.cfg_period = p;
    bus.cfg_high   = h;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    set_cfg(1'b0, 8'd0, 8'd0);

    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    rst = 1'b0;

    // Defaults 4/2, stop by dropping en on the last cycle.
    bus.en = 1'b1;
    per("def_4_2", "1100", 8'd4, 8'd2, -1);
    per("def_4_2", "1100", 8'd4, 8'd2, 3);
    cyc("def_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);

    // Config 5/2 in IDLE.
    set_cfg(1'b1, 8'd5, 8'd2);
    cyc("idle_cfg_5_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 8'd2);
    set_cfg(1'b0, 8'd0, 8'd0);
    bus.en = 1'b1;
    per("run_5_2", "11000", 8'd5, 8'd2, -1);
    per("run_5_2", "11000", 8'd5, 8'd2, 4);
    cyc("idle_5_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 8'd2);

    // Back to 4/2, then 6/3 accepted mid-period.
    set_cfg(1'b1, 8'd4, 8'd2);
    cyc("idle_cfg_4_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    set_cfg(1'b0, 8'd0, 8'd0);
    bus.en = 1'b1;
    cyc("mid_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    set_cfg(1'b1, 8'd6, 8'd3);
    cyc("mid_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd2);
    set_cfg(1'b0, 8'd0, 8'd0);
    cyc("mid_c2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd2);
    cyc("mid_c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd2);
    per("run_6_3", "111000", 8'd6, 8'd3, -1);
    per("run_6_3", "111000", 8'd6, 8'd3, 5);
    cyc("idle_6_3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6, 8'd3);

    // Illegal configs while running 6/3.
    bus.en = 1'b1;
    cyc("ill_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd3);
    set_cfg(1'b1, 8'd1, 8'd0);
    cyc("ill_1_0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6, 8'd3);
    set_cfg(1'b1, 8'd4, 8'd4);
    cyc("ill_4_4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6, 8'd3);
    set_cfg(1'b1, 8'd4, 8'd0);
    cyc("ill_4_0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6, 8'd3);
    set_cfg(1'b0, 8'd0, 8'd0);
    cyc("ill_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd3);
    cyc("ill_c5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd6, 8'd3);
    bus.en = 1'b0;
    cyc("ill_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6, 8'd3);

    // Stop requested at c=1 of 4/2.
    set_cfg(1'b1, 8'd4, 8'd2);
    cyc("idle_cfg_4_2b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    set_cfg(1'b0, 8'd0, 8'd0);
    bus.en = 1'b1;
    cyc("stop_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    cyc("stop_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    bus.en = 1'b0;
    cyc("stop_c2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    cyc("stop_c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    cyc("stop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    cyc("stop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);

    // Stop requested at c=1, re-enabled at c=2: no gap.
    bus.en = 1'b1;
    cyc("resume_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    cyc("resume_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    bus.en = 1'b0;
    cyc("resume_c2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    bus.en = 1'b1;
    cyc("resume_c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    per("resume_next", "1100", 8'd4, 8'd2, 3);
    cyc("resume_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);

    // Reset at c=1 with a pending config.
    bus.en = 1'b1;
    cyc("prst_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    set_cfg(1'b1, 8'd6, 8'd3);
    cyc("prst_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd2);
    set_cfg(1'b0, 8'd0, 8'd0);
    rst = 1'b1;
    bus.en = 1'b0;
    cyc("prst_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    rst = 1'b0;
    bus.en = 1'b1;
    per("post_rst", "1100", 8'd4, 8'd2, 3);
    cyc("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_gen_ctrl.md
Name: clk_gen_ctrl

Overview:
- Synthesizable, runtime-programmable clock-waveform generator and controller.
- Produces a registered divided clock `clk_out` from the system clock with a programmable period and high time (duty cycle).
- Sequences start, stop and reconfiguration so the output never glitches or truncates a period.
- Sits between a config master and any logic needing a slow clock-enable or strobe.

Parameters:
- W, 8, width of period/high counters and config fields.
- DEF_PERIOD, 4, period (in clk cycles) loaded at reset.
- DEF_HIGH, 2, high time (in clk cycles) loaded at reset.
- Legal defaults: 2 <= DEF_PERIOD <= 2^W-1 and 1 <= DEF_HIGH <= DEF_PERIOD-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level: 1 = generate waveform, 0 = stop at end of current period.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  block can accept config this cycle.
- cfg_period  in  W  requested period in cycles.
- cfg_high  in  W  requested high time in cycles.
- cfg_err  out  1  one-cycle pulse: accepted config was illegal and discarded.
- clk_out  out  1  generated waveform (registered).
- rise_tick  out  1  high on the first cycle clk_out is 1 in each period.
- fall_tick  out  1  high on the first cycle clk_out is 0 in each period.
- period_done  out  1  high on the last cycle of each period.
- running  out  1  1 in RUN or STOPPING.
- active_period  out  W  period currently in use.
- active_high  out  W  high time currently in use.

Behaviour:
- Reset (sampled at a clk edge with rst=1):
  - State IDLE; cnt=0; no pending config.
  - clk_out, rise_tick, fall_tick, period_done, cfg_err, running = 0; cfg_ready=1.
  - active_period=DEF_PERIOD; active_high=DEF_HIGH.
  - Reset mid-period aborts immediately; no period completion.
- Config handshake:
  - Transfer occurs on an edge with cfg_valid=1 and cfg_ready=1.
  - Legal means 2 <= cfg_period and 1 <= cfg_high <= cfg_period-1. Illegal transfers are consumed, cfg_err=1 on the next cycle, and active values are unchanged.
  - IDLE: a legal config updates active_* on the next cycle.
  - RUN/STOPPING: a legal config is stored as pending and cfg_ready drops to 0 next cycle. The pending config loads into active_* at the period boundary (the edge where cnt wraps to 0), and cfg_ready returns to 1 the cycle after load.
  - At most one pending config; cfg_ready=0 only while one is held.
- State machine:
  - IDLE -> RUN on an edge sampling en=1. The first RUN cycle has cnt=0.
  - RUN -> STOPPING on an edge sampling en=0 with cnt != 0. If en=0 is sampled when cnt wraps, the block goes directly to IDLE.
  - STOPPING -> RUN if en=1 is sampled before the period ends; the waveform continues seamlessly.
  - STOPPING -> IDLE at the period boundary.
  - Reaching IDLE forces clk_out=0 and cnt=0.
- Waveform:
  - In RUN/STOPPING, during the cycle with count c, clk_out = (c < active_high).
  - cnt increments each cycle and wraps from active_period-1 to 0.
  - period_done=1 when c = active_period-1.
  - rise_tick=1 when c=0; fall_tick=1 when c=active_high.
  - Result: a whole number of periods, and every period has exactly one rise and one fall.
- Simultaneous events:
  - Config accept in the same cycle as a boundary goes to pending and is applied at the next boundary.
  - en fall plus a pending config at a boundary: the config is loaded and the block enters IDLE.
- All arithmetic is unsigned W-bit; cnt never exceeds active_period-1.

Test Plan:
- Reset, en=1 with defaults (4/2) -> clk_out 1,1,0,0 repeating; rise_tick at c=0; fall_tick at c=2; period_done every 4th cycle.
- In IDLE, cfg 5/2 accepted then en=1 -> clk_out 1,1,0,0,0 repeating; active_period=5; active_high=2.
- While running 4/2, cfg 6/3 accepted mid-period -> cfg_ready=0 until boundary; current period completes as 1,1,0,0; next period 1,1,1,0,0,0.
- Illegal cfgs 1/0, 4/4 and 4/0 -> each gives a cfg_err pulse; active_* unchanged; waveform unaffected.
- en drops at c=1 of 4/2 -> clk_out finishes 1,0,0 then stays 0; running drops after period_done. Repeat with en reasserted at c=2 -> no gap in the waveform.
- rst asserted at c=1 while a config is pending -> next cycle: IDLE, outputs 0, active=4/2, cfg_ready=1, pending config discarded.
